// File: rtl/scaler_interp_seq_pkg.sv
// Shared opcode encodings and sequencer state encoding for the horizontal
// upscaler sequencer and its mult_add_2 datapath.
package scaler_interp_seq_pkg;

    localparam logic [1:0] INOP_NOP         = 2'b00;
    localparam logic [1:0] INOP_NORMAL      = 2'b01;
    localparam logic [1:0] INOP_FIR_MODE    = 2'b10;

    localparam logic [1:0] CALCOP_NORMAL    = 2'b00;
    localparam logic [1:0] CALCOP_BYPASS_A0 = 2'b01;
    localparam logic [1:0] CALCOP_BYPASS_A1 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME0 = 3'd1,
        ST_PRIME1 = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/scaler_interp_seq_valid_delay_line.sv
// Fixed-depth 1-bit shift register that re-times the pixel valid flag to the
// datapath output.
module valid_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic CLK_i,
    input  logic nRST_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], valid_i};
        end
    end

    assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/scaler_interp_seq.sv
// Sequencer for linear horizontal upscaling: primes the 2-tap datapath from a
// show-ahead sample buffer, then issues one weighted pixel per cycle.
module scaler_interp_seq
    import scaler_interp_seq_pkg::*;
#(
    parameter int WEIGHT_W  = 8,
    parameter int PHASE_W   = 12,
    parameter int COUNT_W   = 11,
    parameter int POST_REGS = 0
) (
    input  logic                CLK_i,
    input  logic                nRST_i,
    input  logic                line_start_i,
    input  logic [COUNT_W-1:0]  in_len_i,
    input  logic [COUNT_W-1:0]  out_len_i,
    input  logic [PHASE_W-1:0]  step_i,
    input  logic                sample_avail_i,
    output logic                sample_rd_o,
    output logic [1:0]          inopcode_o,
    output logic [1:0]          calcopcode_o,
    output logic [WEIGHT_W-1:0] weight_b0_o,
    output logic [WEIGHT_W-1:0] weight_b1_o,
    output logic                out_valid_o,
    output logic                res_valid_o,
    output logic                busy_o,
    output logic                line_done_o,
    output logic [2:0]          dbg_state_o
);

    localparam int MA_LAT = 3 + POST_REGS;
    localparam logic [COUNT_W:0] ONE = (COUNT_W+1)'(1);
    localparam logic [COUNT_W:0] TWO = (COUNT_W+1)'(2);

    seq_state_e          state_q, state_d;
    logic [COUNT_W-1:0]  in_len_q, in_len_d;
    logic [COUNT_W-1:0]  out_len_q, out_len_d;
    logic [COUNT_W-1:0]  k_q, k_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [PHASE_W-1:0]  f_q, f_d;
    logic                shift_q, shift_d;
    logic [1:0]          inop_q, inop_d;
    logic [1:0]          calc_q, calc_d;
    logic [WEIGHT_W-1:0] b0_q, b0_d;
    logic [WEIGHT_W-1:0] b1_q, b1_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic [PHASE_W:0]    phase_sum;
    logic [COUNT_W:0]    k_ext;
    logic [COUNT_W:0]    len_ext;
    logic [WEIGHT_W-1:0] w;
    logic                at_edge;

    // {k_q, f_q} is the phase of the next pixel; shift_q says that pixel needs a new sample.
    assign phase_sum = {1'b0, f_q} + {1'b0, step_i};
    assign k_ext     = {1'b0, k_q};
    assign len_ext   = {1'b0, in_len_q};
    assign w         = f_q[PHASE_W-1 -: WEIGHT_W];
    assign at_edge   = (k_q == in_len_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        in_len_d  = in_len_q;
        out_len_d = out_len_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        f_d       = f_q;
        shift_d   = shift_q;
        inop_d    = INOP_NOP;
        calc_d    = CALCOP_NORMAL;
        b0_d      = '0;
        b1_d      = '0;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        if (line_start_i) begin
            in_len_d  = in_len_i;
            out_len_d = out_len_i;
            k_d       = '0;
            cnt_d     = '0;
            f_d       = '0;
            shift_d   = 1'b0;
            if (in_len_i == '0 || out_len_i == '0) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_PRIME0;
            end
        end else begin
            case (state_q)
                ST_PRIME0: begin
                    if (sample_avail_i) begin
                        inop_d  = INOP_FIR_MODE;
                        state_d = (in_len_q == COUNT_W'(1)) ? ST_RUN : ST_PRIME1;
                    end
                end
                ST_PRIME1: begin
                    if (sample_avail_i) begin
                        inop_d  = INOP_FIR_MODE;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!(shift_q && !sample_avail_i)) begin
                        valid_d = 1'b1;
                        inop_d  = shift_q ? INOP_FIR_MODE : INOP_NOP;
                        if (at_edge) begin
                            calc_d = CALCOP_BYPASS_A0;
                        end else if (w == '0) begin
                            calc_d = CALCOP_BYPASS_A1;
                        end else begin
                            calc_d = CALCOP_NORMAL;
                            b0_d   = w;
                            b1_d   = -w;
                        end
                        // k saturates at the last sample; only samples up to in_len-1 are ever fetched.
                        f_d     = phase_sum[PHASE_W-1:0];
                        shift_d = phase_sum[PHASE_W] && (k_ext + TWO < len_ext);
                        if (phase_sum[PHASE_W] && (k_ext + ONE < len_ext)) begin
                            k_d = k_q + 1'b1;
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == out_len_q - 1'b1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state_q   <= ST_IDLE;
            in_len_q  <= '0;
            out_len_q <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            f_q       <= '0;
            shift_q   <= 1'b0;
            inop_q    <= INOP_NOP;
            calc_q    <= CALCOP_NORMAL;
            b0_q      <= '0;
            b1_q      <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_len_q  <= in_len_d;
            out_len_q <= out_len_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            f_q       <= f_d;
            shift_q   <= shift_d;
            inop_q    <= inop_d;
            calc_q    <= calc_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    valid_delay_line #(
        .DEPTH(MA_LAT)
    ) u_res_valid (
        .CLK_i  (CLK_i),
        .nRST_i (nRST_i),
        .valid_i(valid_q),
        .valid_o(res_valid_o)
    );

    assign sample_rd_o  = (inop_q == INOP_FIR_MODE);
    assign inopcode_o   = inop_q;
    assign calcopcode_o = calc_q;
    assign weight_b0_o  = b0_q;
    assign weight_b1_o  = b1_q;
    assign out_valid_o  = valid_q;
    assign line_done_o  = done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_scaler_interp_seq.sv
// Bench for scaler_interp_seq: per-cycle comparison against a phase-arithmetic
// model of the pixel schedule, plus a small datapath model for pixel values.
module tb_scaler_interp_seq;

    localparam int VW = 25;

    logic        CLK_i = 1'b0;
    logic        nRST_i;
    logic        line_start_i;
    logic [10:0] in_len_i;
    logic [10:0] out_len_i;
    logic [11:0] step_i;
    logic        sample_avail_i;
    logic        sample_rd_o;
    logic [1:0]  inopcode_o;
    logic [1:0]  calcopcode_o;
    logic [7:0]  weight_b0_o;
    logic [7:0]  weight_b1_o;
    logic        out_valid_o;
    logic        res_valid_o;
    logic        busy_o;
    logic        line_done_o;
    logic [2:0]  dbg_state_o;

    int vectors     = 0;
    int miscompares = 0;

    // expected out_valid history: [0] = last cycle, [2] = three cycles ago
    logic [2:0] ov_hist = 3'b000;

    int  x_mem [16];
    int  exp_res[$];
    int  rd_cnt;
    int  dp_a0;
    int  dp_a1;
    bit  track_data = 1'b0;

    scaler_interp_seq #(
        .WEIGHT_W (8),
        .PHASE_W  (12),
        .COUNT_W  (11),
        .POST_REGS(0)
    ) dut (
        .CLK_i         (CLK_i),
        .nRST_i        (nRST_i),
        .line_start_i  (line_start_i),
        .in_len_i      (in_len_i),
        .out_len_i     (out_len_i),
        .step_i        (step_i),
        .sample_avail_i(sample_avail_i),
        .sample_rd_o   (sample_rd_o),
        .inopcode_o    (inopcode_o),
        .calcopcode_o  (calcopcode_o),
        .weight_b0_o   (weight_b0_o),
        .weight_b1_o   (weight_b1_o),
        .out_valid_o   (out_valid_o),
        .res_valid_o   (res_valid_o),
        .busy_o        (busy_o),
        .line_done_o   (line_done_o),
        .dbg_state_o   (dbg_state_o)
    );

    // clock / watchdog
    always #5 CLK_i = ~CLK_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] observed();
        return {out_valid_o, sample_rd_o, inopcode_o, calcopcode_o,
                weight_b0_o, weight_b1_o, line_done_o, busy_o, res_valid_o};
    endfunction

    task automatic idle_cycles(input int n, input string tag);
        logic [VW-1:0] exp_v;
        logic [VW-1:0] act_v;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_i); #1;
            exp_v = {22'd0, 1'b0, 1'b0, ov_hist[2]};
            act_v = observed();
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s idle%0d: got %h expected %h", tag, i, act_v, exp_v);
            end
            ov_hist = {ov_hist[1:0], 1'b0};
        end
    endtask

    // Drives one line and checks every cycle. abort_after >= 0 returns right
    // after that many pixels were issued, leaving the line running.
    task automatic run_line(input int in_len, input int out_len, input int step,
                            input int stall_mode, input int abort_after, input string tag);
        logic [21:0]   ops[$];
        bit            shf[$];
        logic [21:0]   e;
        logic [VW-1:0] exp_v;
        logic [VW-1:0] act_v;
        int            prime_n, idx, pix, stalls3, budget, res;
        bit            zero_len, avail, aborted;

        zero_len = (in_len == 0) || (out_len == 0);
        prime_n  = (in_len >= 2) ? 2 : 1;
        if (!zero_len) begin
            for (int i = 0; i < prime_n; i++) begin
                ops.push_back({1'b0, 1'b1, 2'b10, 2'b00, 8'd0, 8'd0});
                shf.push_back(1'b1);
            end
            for (int j = 0; j < out_len; j++) begin
                longint     p;
                int         pk, ppk, f, w;
                bit         s;
                logic [1:0] c;
                logic [7:0] b0, b1;
                p   = longint'(j) * step;
                pk  = int'(p >> 12);
                f   = int'(p & 64'hfff);
                ppk = (j == 0) ? 0 : int'((longint'(j - 1) * step) >> 12);
                s   = (j > 0) && (pk > ppk) && (pk < in_len - 1);
                w   = f >> 4;
                b0  = 8'd0;
                b1  = 8'd0;
                if (pk >= in_len - 1) begin
                    c = 2'b01;
                end else if (w == 0) begin
                    c = 2'b10;
                end else begin
                    c  = 2'b00;
                    b0 = w[7:0];
                    b1 = 8'(256 - w);
                end
                ops.push_back({1'b1, s, (s ? 2'b10 : 2'b00), c, b0, b1});
                shf.push_back(s);
            end
        end

        rd_cnt = 0;
        dp_a0  = 0;
        dp_a1  = 0;

        in_len_i       = 11'(in_len);
        out_len_i      = 11'(out_len);
        step_i         = 12'(step);
        line_start_i   = 1'b1;
        sample_avail_i = 1'($urandom_range(0, 1));
        @(posedge CLK_i); #1;
        line_start_i = 1'b0;
        exp_v = {22'd0, zero_len, !zero_len, ov_hist[2]};
        act_v = observed();
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s start: got %h expected %h", tag, act_v, exp_v);
        end
        ov_hist = {ov_hist[1:0], 1'b0};

        if (zero_len) begin
            idle_cycles(1, tag);
            return;
        end

        idx     = 0;
        pix     = 0;
        stalls3 = 0;
        budget  = 0;
        aborted = 1'b0;
        while (idx < ops.size()) begin
            if (abort_after >= 0 && pix == abort_after) begin
                aborted = 1'b1;
                break;
            end
            if (budget >= 400) begin
                vectors++;
                miscompares++;
                $display("FAIL %s timeout: issued %0d of %0d ops", tag, idx, ops.size());
                aborted = 1'b1;
                break;
            end
            case (stall_mode)
                1:       avail = ($urandom_range(0, 3) != 0);
                2:       avail = !(idx == prime_n + 2 && stalls3 < 3);
                default: avail = 1'b1;
            endcase
            if (!avail && idx == prime_n + 2) stalls3++;
            sample_avail_i = avail;
            @(posedge CLK_i); #1;
            budget++;
            if (shf[idx] && !avail) begin
                e = '0;
            end else begin
                e = ops[idx];
                idx++;
                if (e[21]) pix++;
            end
            exp_v = {e, 1'b0, 1'b1, ov_hist[2]};
            act_v = observed();
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle%0d: got %h expected %h", tag, budget, act_v, exp_v);
            end
            ov_hist = {ov_hist[1:0], e[21]};

            if (track_data) begin
                if (sample_rd_o) begin
                    dp_a1 = dp_a0;
                    dp_a0 = (rd_cnt < 16) ? x_mem[rd_cnt] : -1;
                    rd_cnt++;
                end
                if (out_valid_o) begin
                    case (calcopcode_o)
                        2'b01:   res = dp_a0;
                        2'b10:   res = dp_a1;
                        default: res = (dp_a0 * int'(weight_b0_o) + dp_a1 * int'(weight_b1_o)) >> 8;
                    endcase
                    vectors++;
                    if (exp_res.size() == 0) begin
                        miscompares++;
                        $display("FAIL %s pixel_value: got %0d expected none", tag, res);
                    end else begin
                        if (res !== exp_res[0]) begin
                            miscompares++;
                            $display("FAIL %s pixel_value: got %0d expected %0d", tag, res, exp_res[0]);
                        end
                        void'(exp_res.pop_front());
                    end
                end
            end
        end
        sample_avail_i = 1'b0;

        if (!aborted) begin
            @(posedge CLK_i); #1;
            exp_v = {22'd0, 1'b1, 1'b0, ov_hist[2]};
            act_v = observed();
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s line_done: got %h expected %h", tag, act_v, exp_v);
            end
            ov_hist = {ov_hist[1:0], 1'b0};
        end
    endtask

    task automatic test_reset();
        nRST_i         = 1'b0;
        line_start_i   = 1'b0;
        in_len_i       = '0;
        out_len_i      = '0;
        step_i         = '0;
        sample_avail_i = 1'b0;
        repeat (2) @(posedge CLK_i);
        #1;
        vectors++;
        if (observed() !== '0 || dbg_state_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset: got %h state %0d expected all zero", observed(), dbg_state_o);
        end
        @(negedge CLK_i);
        nRST_i = 1'b1;
        idle_cycles(2, "post_reset");
    endtask

    task automatic check_data_end(input int exp_reads, input string tag);
        vectors++;
        if (rd_cnt != exp_reads || exp_res.size() != 0) begin
            miscompares++;
            $display("FAIL %s reads: got %0d reads (%0d pixels missing) expected %0d reads",
                     tag, rd_cnt, exp_res.size(), exp_reads);
        end
        exp_res.delete();
    endtask

    task automatic test_half_step();
        x_mem[0] = 0; x_mem[1] = 100; x_mem[2] = 200; x_mem[3] = 40;
        exp_res = '{0, 50, 100, 150, 200, 120, 40, 40};
        track_data = 1'b1;
        run_line(4, 8, 'h800, 0, -1, "half_step");
        track_data = 1'b0;
        check_data_end(4, "half_step");
        idle_cycles(4, "half_step_drain");
    endtask

    task automatic test_stall();
        x_mem[0] = 0; x_mem[1] = 100; x_mem[2] = 200; x_mem[3] = 40;
        exp_res = '{0, 50, 100, 150, 200, 120, 40, 40};
        track_data = 1'b1;
        run_line(4, 8, 'h800, 2, -1, "stall");
        track_data = 1'b0;
        check_data_end(4, "stall");
        idle_cycles(4, "stall_drain");
    endtask

    task automatic test_single_sample();
        x_mem[0] = 77;
        exp_res = '{77, 77, 77};
        track_data = 1'b1;
        run_line(1, 3, 'h5a0, 0, -1, "single_sample");
        track_data = 1'b0;
        check_data_end(1, "single_sample");
        idle_cycles(4, "single_drain");
    endtask

    task automatic test_zero_len();
        run_line(0, 5, 'h800, 0, -1, "zero_in_len");
        run_line(3, 0, 'h800, 0, -1, "zero_out_len");
        idle_cycles(2, "zero_drain");
    endtask

    task automatic test_restart();
        run_line(4, 8, 'h800, 0, 3, "restart_first");
        run_line(4, 8, 'h800, 0, -1, "restart_second");
        idle_cycles(4, "restart_drain");
    endtask

    task automatic test_async_reset();
        run_line(4, 8, 'h800, 0, 3, "pre_reset");
        #3;
        nRST_i = 1'b0;
        #1;
        vectors++;
        if (observed() !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected all zero", observed());
        end
        ov_hist = 3'b000;
        @(posedge CLK_i); #1;
        nRST_i = 1'b1;
        idle_cycles(5, "after_async_reset");
        run_line(3, 5, 'h555, 0, -1, "line_after_reset");
        idle_cycles(4, "after_reset_drain");
    endtask

    task automatic test_random();
        int il, ol, st;
        for (int n = 0; n < 10; n++) begin
            il = $urandom_range(1, 12);
            ol = $urandom_range(1, 24);
            st = $urandom_range(1, 4095);
            run_line(il, ol, st, 1, -1, $sformatf("rand%0d", n));
            idle_cycles($urandom_range(0, 3), "rand_gap");
        end
        idle_cycles(4, "rand_drain");
    endtask

    initial begin
        test_reset();
        test_half_step();
        test_stall();
        test_single_sample();
        test_zero_len();
        test_restart();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
